// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared digit codes, converter state type and pow10 helper
package bcd_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'd10;
  localparam logic [3:0] DIGIT_DASH  = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FINAL = 2'd2
  } state_t;

  // 10^n evaluated at elaboration to size the display range
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble correction: add 3 to a nibble that is 5 or more
module bcd_add3 (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  // pre-shift correction so the nibble carries into the next decade after doubling
  always_comb begin
    nib_out = (nib_in >= 4'd5) ? (nib_in + 4'd3) : nib_in;
  end

endmodule

// File: rtl/bin_to_bcd_digits.sv
// rtl/bin_to_bcd_digits.sv - iterative binary to BCD digit codes; optional BCD_LEADING_ZERO_BLANK_EN
module bin_to_bcd_digits
  import bcd_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] digits
);

  localparam int          BCD_W   = 4 * N_DIGITS;
  localparam int          CNT_W   = $clog2(IN_W + 1);
  localparam logic [63:0] MAX_VAL = pow10(N_DIGITS) - 64'd1;

  state_t           state;
  state_t           state_next;
  logic [IN_W-1:0]  shreg;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] result;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_in  (bcd[4*k +: 4]),
      .nib_out (bcd_adj[4*k +: 4])
    );
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next state and busy; start is only looked at in IDLE so it never queues
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // final digit codes: dashes on overflow, otherwise the BCD result
  always_comb begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic lead;
    result = bcd;
    lead   = 1'b1;
    // blank zeros above the most significant non-zero digit; digit 0 always shows
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      if (lead && (bcd[4*k +: 4] == 4'd0)) begin
        result[4*k +: 4] = DIGIT_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
`else
    result = bcd;
`endif
    if (ovf) begin
      result = {N_DIGITS{DIGIT_DASH}};
    end
  end

  // datapath: capture, one shift step per edge, publish on the FINAL edge
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      bcd    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      digits <= {N_DIGITS{DIGIT_BLANK}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= bin;
            bcd   <= '0;
            cnt   <= CNT_W'(IN_W);
            ovf   <= (64'(bin) > MAX_VAL);
          end
        end
        SHIFT: begin
          {bcd, shreg} <= {bcd_adj, shreg} << 1;
          cnt          <= cnt - CNT_W'(1);
        end
        FINAL: begin
          digits <= result;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// tb/tb_bin_to_bcd_digits.sv - self-checking bench for bin_to_bcd_digits
module tb_bin_to_bcd_digits;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic [15:0] bin = 16'd0;
  logic        busy, done, busy4, done4;
  logic [19:0] digits;
  logic [15:0] digits4;

  int total = 0;
  int bad   = 0;
  logic [19:0] sb[$];

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[14];

  bin_to_bcd_digits #(.IN_W(16), .N_DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .digits(digits)
  );

  bin_to_bcd_digits #(.IN_W(16), .N_DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bin(bin),
    .busy(busy4), .done(done4), .digits(digits4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // reference conversion by repeated division
  function automatic logic [19:0] ref_digits(input int v, input int nd);
    logic [19:0] r;
    int lim;
    int x;
    r   = '0;
    lim = 1;
    for (int i = 0; i < nd; i++) lim *= 10;
    if (v >= lim) begin
      for (int k = 0; k < nd; k++) r[4*k +: 4] = 4'd11;
      return r;
    end
    x = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BCD_LEADING_ZERO_BLANK_EN
    for (int k = nd - 1; k > 0; k--) begin
      if (r[4*k +: 4] != 4'd0) break;
      r[4*k +: 4] = 4'd10;
    end
`endif
    return r;
  endfunction

  task automatic launch(input logic [15:0] val, input logic [19:0] exp);
    bin   = val;
    start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = 16'($urandom);
  endtask

  // wait for done; returns at the negedge where done is high
  task automatic finish_conv(input string name, input int exp_busy);
    int nb;
    bit seen;
    logic [19:0] e;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) nb++;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_digits"}, 32'(digits), 32'(e));
      check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    end
    if (exp_busy > 0) check({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  task automatic run4(input logic [15:0] val, input logic [15:0] exp, input string name);
    bit seen;
    seen   = 1'b0;
    bin    = val;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_digits"}, 32'(digits4), 32'(exp));
  endtask

  initial begin
    int npulse;

    vecs[0] = '{16'd12345, 20'h12345};
`ifdef BCD_LEADING_ZERO_BLANK_EN
    vecs[1] = '{16'd42, 20'hAAA42};
    vecs[2] = '{16'd0,  20'hAAAA0};
    vecs[3] = '{16'd9,  20'hAAAA9};
    vecs[4] = '{16'd100, 20'hAA100};
`else
    vecs[1] = '{16'd42, 20'h00042};
    vecs[2] = '{16'd0,  20'h00000};
    vecs[3] = '{16'd9,  20'h00009};
    vecs[4] = '{16'd100, 20'h00100};
`endif
    vecs[5] = '{16'd65535, 20'h65535};
    vecs[6] = '{16'd60001, 20'h60001};
    vecs[7] = '{16'd10000, 20'h10000};
    for (int i = 8; i < 14; i++) begin
      vecs[i].bin = 16'($urandom_range(0, 65535));
      vecs[i].exp = ref_digits(int'(vecs[i].bin), 5);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_digits", 32'(digits), 32'h000AAAAA);
    check("reset_digits4", 32'(digits4), 32'h0000AAAA);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      launch(vecs[i].bin, vecs[i].exp);
      finish_conv($sformatf("vec%0d", i), 17);
      @(negedge clk);
      check($sformatf("vec%0d_done_width", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_digits_hold", i), 32'(digits), 32'(vecs[i].exp));
    end

    // start while busy is ignored
`ifdef BCD_LEADING_ZERO_BLANK_EN
    launch(16'd777, 20'hAA777);
`else
    launch(16'd777, 20'h00777);
`endif
    repeat (5) @(negedge clk);
    bin   = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_conv("busy_start", 0);
    npulse = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) npulse++;
    end
    check("busy_start_no_requeue", 32'(npulse), 32'd0);

    // start in the done cycle is accepted
    launch(16'd500, ref_digits(500, 5));
    finish_conv("pre_done_start", 17);
    launch(16'd12345, 20'h12345);
    finish_conv("done_cycle_start", 17);
    @(negedge clk);

    // reset in the middle of a conversion
    launch(16'd65535, 20'h65535);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_digits", 32'(digits), 32'h000AAAAA);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    check("midrst_no_done", 32'(npulse), 32'd0);
    launch(16'd65535, 20'h65535);
    finish_conv("after_rst", 17);
    @(negedge clk);

    // four-digit instance: overflow boundary
    run4(16'd12345, 16'hBBBB, "ovf_12345");
    run4(16'd9999,  16'h9999, "max_9999");
    run4(16'd10000, 16'hBBBB, "ovf_10000");
    run4(16'd65535, 16'hBBBB, "ovf_65535");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
